// File: rtl/pipe_p23_hazard_pkg.sv
// Shared processor parameters for the p2/p3 pipeline stage: widths, opcodes and stall defaults.
package pipe_p23_hazard_pkg;

    localparam int DATA_WIDTH        = 16;
    localparam int REG_ADDR_WIDTH    = 5;
    localparam int CTRL_WIDTH        = 4;
    localparam int LOAD_STALL_CYCLES = 1;
    localparam int BUB_CNT_WIDTH     = 4;

    localparam logic [CTRL_WIDTH-1:0] NOP = 4'h0;
    localparam logic [CTRL_WIDTH-1:0] ADD = 4'h1;
    localparam logic [CTRL_WIDTH-1:0] SUB = 4'h2;
    localparam logic [CTRL_WIDTH-1:0] AND = 4'h3;
    localparam logic [CTRL_WIDTH-1:0] OR  = 4'h4;
    localparam logic [CTRL_WIDTH-1:0] LW  = 4'h8;
    localparam logic [CTRL_WIDTH-1:0] SW  = 4'h9;
    localparam logic [CTRL_WIDTH-1:0] BEQ = 4'hA;

endpackage

// File: rtl/pipe_p23_hazard_detect.sv
// load_use_detect: flags a p2 instruction that reads the destination of a load sitting in p3.
module load_use_detect #(
    parameter int CTRL_WIDTH     = pipe_p23_hazard_pkg::CTRL_WIDTH,
    parameter int REG_ADDR_WIDTH = pipe_p23_hazard_pkg::REG_ADDR_WIDTH
) (
    input  logic [CTRL_WIDTH-1:0]     i_ctrl,
    input  logic [CTRL_WIDTH-1:0]     i_ctrl_p23,
    input  logic [REG_ADDR_WIDTH-1:0] i_a_addr,
    input  logic [REG_ADDR_WIDTH-1:0] i_b_addr,
    input  logic [REG_ADDR_WIDTH-1:0] i_reg_addr_p23,
    output logic                      o_hz
);
    import pipe_p23_hazard_pkg::*;

    localparam logic [CTRL_WIDTH-1:0] CtrlNop = CTRL_WIDTH'(NOP);
    localparam logic [CTRL_WIDTH-1:0] CtrlLw  = CTRL_WIDTH'(LW);

    logic w_load_in_p3;
    logic w_p2_valid;
    logic w_src_match;

    assign w_load_in_p3 = (i_ctrl_p23 == CtrlLw);
    assign w_p2_valid   = (i_ctrl != CtrlNop);
    assign w_src_match  = (i_a_addr == i_reg_addr_p23) || (i_b_addr == i_reg_addr_p23);

    assign o_hz = w_load_in_p3 && w_p2_valid && w_src_match;

endmodule

// File: rtl/pipe_p23_hazard.sv
// p2->p3 pipeline register with load-use stall and NOP bubble injection.
// Defining PIPE_STALL_CNT_EN adds the saturating stall_cnt performance counter.
module pipe_p23_hazard #(
    parameter int DATA_WIDTH        = pipe_p23_hazard_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH    = pipe_p23_hazard_pkg::REG_ADDR_WIDTH,
    parameter int CTRL_WIDTH        = pipe_p23_hazard_pkg::CTRL_WIDTH,
    parameter int LOAD_STALL_CYCLES = pipe_p23_hazard_pkg::LOAD_STALL_CYCLES,
    parameter int STALL_CNT_WIDTH   = 16
) (
    input  logic                             clk,
    input  logic                             RST,
    input  logic                             hold,
    input  logic                             flush,
    input  logic        [CTRL_WIDTH-1:0]     ctrl,
    input  logic        [REG_ADDR_WIDTH-1:0] A_addr,
    input  logic        [REG_ADDR_WIDTH-1:0] B_addr,
    input  logic        [REG_ADDR_WIDTH-1:0] reg_addr_p2,
    input  logic signed [DATA_WIDTH-1:0]     muxA_data,
    input  logic signed [DATA_WIDTH-1:0]     muxB_data,
    output logic        [CTRL_WIDTH-1:0]     ctrl_p23,
    output logic        [REG_ADDR_WIDTH-1:0] reg_addr_p23,
    output logic signed [DATA_WIDTH-1:0]     dataA_p23,
    output logic signed [DATA_WIDTH-1:0]     dataB_p23,
    output logic                             stall
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic        [STALL_CNT_WIDTH-1:0] stall_cnt
`endif
);
    import pipe_p23_hazard_pkg::*;

    typedef enum logic {StRun, StStall} state_t;

    localparam logic [CTRL_WIDTH-1:0]    CtrlNop = CTRL_WIDTH'(NOP);
    localparam logic [BUB_CNT_WIDTH-1:0] BubInit = BUB_CNT_WIDTH'(LOAD_STALL_CYCLES - 1);
    localparam logic [BUB_CNT_WIDTH-1:0] BubOne  = BUB_CNT_WIDTH'(1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [BUB_CNT_WIDTH-1:0]   r_bub_cnt;
    logic [BUB_CNT_WIDTH-1:0]   w_bub_cnt_nxt;

    logic [CTRL_WIDTH-1:0]      r_ctrl_p23;
    logic [REG_ADDR_WIDTH-1:0]  r_reg_addr_p23;
    logic signed [DATA_WIDTH-1:0] r_dataA_p23;
    logic signed [DATA_WIDTH-1:0] r_dataB_p23;

    logic w_hz;
    logic w_bubble;
    logic w_stall;

    load_use_detect #(
        .CTRL_WIDTH    (CTRL_WIDTH),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_load_use_detect (
        .i_ctrl        (ctrl),
        .i_ctrl_p23    (r_ctrl_p23),
        .i_a_addr      (A_addr),
        .i_b_addr      (B_addr),
        .i_reg_addr_p23(r_reg_addr_p23),
        .o_hz          (w_hz)
    );

    assign w_stall = !hold && !flush && ((r_state == StRun && w_hz) || r_state == StStall);

    // Hold is applied at the register enable, so this only decides what a live edge does.
    always_comb begin
        w_state_nxt   = r_state;
        w_bub_cnt_nxt = r_bub_cnt;
        w_bubble      = 1'b0;
        if (flush) begin
            w_state_nxt   = StRun;
            w_bub_cnt_nxt = '0;
            w_bubble      = 1'b1;
        end else if (r_state == StStall) begin
            w_bubble      = 1'b1;
            w_bub_cnt_nxt = r_bub_cnt - BubOne;
            if (r_bub_cnt == BubOne) begin
                w_state_nxt = StRun;
            end
        end else if (w_hz) begin
            w_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                w_bub_cnt_nxt = BubInit;
                w_state_nxt   = StStall;
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state   <= StRun;
            r_bub_cnt <= '0;
        end else if (!hold) begin
            r_state   <= w_state_nxt;
            r_bub_cnt <= w_bub_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_ctrl_p23     <= CtrlNop;
            r_reg_addr_p23 <= '0;
            r_dataA_p23    <= '0;
            r_dataB_p23    <= '0;
        end else if (!hold) begin
            if (w_bubble) begin
                r_ctrl_p23     <= CtrlNop;
                r_reg_addr_p23 <= '0;
                r_dataA_p23    <= '0;
                r_dataB_p23    <= '0;
            end else begin
                r_ctrl_p23     <= ctrl;
                r_reg_addr_p23 <= reg_addr_p2;
                r_dataA_p23    <= muxA_data;
                r_dataB_p23    <= muxB_data;
            end
        end
    end

    assign ctrl_p23     = r_ctrl_p23;
    assign reg_addr_p23 = r_reg_addr_p23;
    assign dataA_p23    = r_dataA_p23;
    assign dataB_p23    = r_dataB_p23;
    assign stall        = w_stall;

`ifdef PIPE_STALL_CNT_EN
    logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

    // w_stall already excludes hold, so no separate enable is needed.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_WIDTH'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
